serial_subtractor64: RTL and testbench

//  Multi-cycle unsigned subtractor that computes diff = a - b for the ALU path.
//  It works digit-serially: one DIGIT-bit slice per clock, reusing a single

---
 rtl/serial_subtractor64.sv | 146 ++++++++++++++
 tb/tb_serial_subtractor64.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor64.sv
// ---------------------------------------------------------------------------
// serial_subtractor64
//
// Purpose:
//   Multi-cycle unsigned subtractor, diff = a - b (mod 2^WIDTH). One DIGIT-bit
//   slice is processed per clock through a single DIGIT+1 bit adder computing
//   a + ~b + carry. The carry links one digit to the next only through
//   carry_q. A full operation takes N = WIDTH/DIGIT RUN cycles.
//   WIDTH must be a multiple of DIGIT.
//
// Ports:
//   clk     in   1      rising-edge clock
//   rst     in   1      asynchronous, active-high reset
//   start   in   1      operation request, sampled only while idle
//   a       in   WIDTH  minuend, captured on the accepting edge
//   b       in   WIDTH  subtrahend, captured on the accepting edge
//   busy    out  1      high while an operation is in flight
//   done    out  1      one-cycle pulse: diff/borrow/zero just updated
//   diff    out  WIDTH  a - b mod 2^WIDTH, held until the next result
//   borrow  out  1      1 when a < b (unsigned), i.e. the inverted final carry
//   zero    out  1      1 when diff == 0
// ---------------------------------------------------------------------------
module serial_subtractor64 #(
    parameter int WIDTH = 64,
    parameter int DIGIT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] sa_q;
    logic [WIDTH-1:0] sb_q;
    logic [WIDTH-1:0] res_q;
    logic             carry_q;
    logic [CW-1:0]    count_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic             zero_q;

    logic [DIGIT:0]   digit_sum;
    logic [WIDTH-1:0] res_d;
    logic [WIDTH-1:0] sa_d;
    logic [WIDTH-1:0] sb_d;
    logic             last_digit;

    // Single digit adder: low slice of the shifting operands plus the carry
    // left over from the previous digit. The MSB of digit_sum is the carry out.
    always_comb begin
        digit_sum = {1'b0, sa_q[DIGIT-1:0]}
                  + {1'b0, ~sb_q[DIGIT-1:0]}
                  + {{DIGIT{1'b0}}, carry_q};
    end

    assign sa_d       = sa_q >> DIGIT;
    assign sb_d       = sb_q >> DIGIT;
    assign last_digit = (count_q == CW'(N - 1));

    // Result digits enter from the MSB end, so after N shifts the first digit
    // computed (the least significant) has arrived at bit 0.
    generate
        if (N > 1) begin : g_res_shift
            assign res_d = {digit_sum[DIGIT-1:0], res_q[WIDTH-1:DIGIT]};
        end else begin : g_res_single
            assign res_d = digit_sum[DIGIT-1:0];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            res_q    <= '0;
            carry_q  <= 1'b0;
            count_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            // done is a single-cycle pulse unless re-raised below.
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        sa_q    <= a;
                        sb_q    <= b;
                        res_q   <= '0;
                        // Carry-in of 1 turns ~b into -b (two's complement).
                        carry_q <= 1'b1;
                        count_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    carry_q <= digit_sum[DIGIT];
                    sa_q    <= sa_d;
                    sb_q    <= sb_d;
                    res_q   <= res_d;
                    count_q <= count_q + CW'(1);
                    if (last_digit) begin
                        // Only the completed result ever reaches the outputs.
                        diff_q   <= res_d;
                        borrow_q <= ~digit_sum[DIGIT];
                        zero_q   <= (res_d == '0);
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign diff   = diff_q;
    assign borrow = borrow_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_serial_subtractor64.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor64
//
// Purpose:
//   Self-checking bench for serial_subtractor64 at default parameters
//   (WIDTH=64, DIGIT=8, N=8). Directed vectors with hand-computed results,
//   then random operand pairs checked against the plain 64-bit expression
//   (a - b, a < b). Cycle-exact checks of busy/done timing, output holding,
//   ignored starts while busy, back-to-back starts in the done cycle and
//   asynchronous reset mid-operation.
// ---------------------------------------------------------------------------
module tb_serial_subtractor64;

    localparam int N = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] a;
    logic [63:0] b;
    logic        busy;
    logic        done;
    logic [63:0] diff;
    logic        borrow;
    logic        zero;

    int checks = 0;
    int errors = 0;

    // Values the registered outputs must hold until the next done pulse.
    logic [63:0] hold_diff;
    logic        hold_borrow;
    logic        hold_zero;

    always #5 clk = ~clk;

    serial_subtractor64 #(
        .WIDTH (64),
        .DIGIT (8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow),
        .zero   (zero)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Called 1 time unit after a rising edge. Presents an operation, lets the
    // next edge accept it, then scrambles a/b to prove they were captured.
    task automatic start_op(input logic [63:0] av, input logic [63:0] bv);
        start = 1'b1;
        a     = av;
        b     = bv;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = {$urandom, $urandom};
        b     = {$urandom, $urandom};
        check("busy_after_accept", busy, 1);
        check("done_after_accept", done, 0);
    endtask

    // Runs the N RUN cycles after the accepting edge. junk_cyc > 0 raises a
    // start request (a=100, b=1) in that cycle, which must be ignored.
    task automatic finish_op(input string tag, input logic [63:0] ed,
                             input logic eb, input logic ez, input int junk_cyc);
        for (int i = 1; i <= N; i++) begin
            if (i == junk_cyc) begin
                start = 1'b1;
                a     = 64'd100;
                b     = 64'd1;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (i < N) begin
                check({tag, "_busy_run"}, busy, 1);
                check({tag, "_done_run"}, done, 0);
                check({tag, "_diff_hold"}, diff, hold_diff);
                check({tag, "_borrow_hold"}, borrow, hold_borrow);
                check({tag, "_zero_hold"}, zero, hold_zero);
            end else begin
                check({tag, "_done"}, done, 1);
                check({tag, "_busy_end"}, busy, 0);
                check({tag, "_diff"}, diff, ed);
                check({tag, "_borrow"}, borrow, eb);
                check({tag, "_zero"}, zero, ez);
                $display("op %s: diff=%h borrow=%0d zero=%0d (exp %h %0d %0d)",
                         tag, diff, borrow, zero, ed, eb, ez);
            end
        end
        hold_diff   = ed;
        hold_borrow = eb;
        hold_zero   = ez;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check("idle_done", done, 0);
            check("idle_busy", busy, 0);
            check("idle_diff_hold", diff, hold_diff);
        end
    endtask

    initial begin
        logic [63:0] av;
        logic [63:0] bv;

        rst         = 1'b1;
        start       = 1'b0;
        a           = '0;
        b           = '0;
        hold_diff   = '0;
        hold_borrow = 1'b0;
        hold_zero   = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_diff", diff, 0);
        check("rst_borrow", borrow, 0);
        check("rst_zero", zero, 0);
        rst = 1'b0;
        idle(1);

        // 1: simple difference
        start_op(64'd10, 64'd3);
        finish_op("t1_10m3", 64'd7, 1'b0, 1'b0, 0);
        idle(1);

        // 2: full wrap-around with borrow
        start_op(64'd0, 64'd1);
        finish_op("t2_0m1", 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 0);
        idle(1);

        // 3: borrow rippling across several digits
        start_op(64'h0000_0001_0000_0000, 64'd1);
        finish_op("t3_cross", 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0, 0);
        idle(1);

        // 4: equal operands give zero
        start_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
        finish_op("t4_eq", 64'd0, 1'b0, 1'b1, 0);
        idle(1);

        // 5: start while busy is ignored; start in the done cycle is accepted
        start_op(64'd5, 64'd2);
        finish_op("t5_ignore", 64'd3, 1'b0, 1'b0, 3);
        start_op(64'd100, 64'd1);
        finish_op("t5_b2b", 64'd99, 1'b0, 1'b0, 0);
        idle(2);

        // 6: asynchronous reset in RUN cycle 4 abandons the operation
        start_op(64'd9, 64'd4);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("t6_rst_busy", busy, 0);
        check("t6_rst_done", done, 0);
        check("t6_rst_diff", diff, 0);
        check("t6_rst_borrow", borrow, 0);
        check("t6_rst_zero", zero, 0);
        @(posedge clk);
        #1;
        rst         = 1'b0;
        hold_diff   = '0;
        hold_borrow = 1'b0;
        hold_zero   = 1'b0;
        idle(N + 2);
        start_op(64'd9, 64'd4);
        finish_op("t6_after_rst", 64'd5, 1'b0, 1'b0, 0);

        // Random pairs with random gaps (gap 0 starts in the done cycle).
        for (int k = 0; k < 2000; k++) begin
            av = {$urandom, $urandom};
            bv = {$urandom, $urandom};
            if (k % 8 == 0) bv = av;
            if (k % 8 == 1) bv = av + 64'd1;
            idle($urandom_range(0, 3));
            start_op(av, bv);
            finish_op("rand", av - bv, (av < bv), ((av - bv) == 64'd0), 0);
        end
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
